// File: rtl/swap_reg_bank.sv
// rtl/swap_reg_bank.sv - NREG x WIDTH register bank: load/inc/dec/swap/copy/clr, falling-edge state
// Define SWAP_REG_SAT_EN to make INC/DEC saturate instead of wrapping.
module swap_reg_bank #(
    parameter int WIDTH   = 18,
    parameter int NREG    = 4,
    parameter int AW      = 2,
    parameter int RST_VAL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2:0]             op,
    input  logic [AW-1:0]          sel_a,
    input  logic [AW-1:0]          sel_b,
    input  logic [WIDTH-1:0]       bus_in,
    output logic [WIDTH-1:0]       rd_a,
    output logic [NREG*WIDTH-1:0]  regs_flat,
    output logic                   zero,
    output logic                   carry,
    output logic                   ack,
    output logic                   err
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_COPY = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

    logic [NREG-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]           rd_b;
    logic [WIDTH-1:0]           wdata;
    logic [WIDTH:0]             inc_sum;
    logic [WIDTH:0]             dec_diff;
    logic                       carry_next;
    logic                       a_ok;
    logic                       b_ok;
    logic                       needs_b;
    logic                       accept;
    logic                       reject;

    // Select decode doubles as the range check, so NREG need not be a power of two.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        a_ok = 1'b0;
        b_ok = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_a == AW'(i)) begin
                rd_a = regs[i];
                a_ok = 1'b1;
            end
            if (sel_b == AW'(i)) begin
                rd_b = regs[i];
                b_ok = 1'b1;
            end
        end
    end

    assign inc_sum  = {1'b0, rd_a} + (WIDTH+1)'(1);
    assign dec_diff = {1'b0, rd_a} - (WIDTH+1)'(1);

    always_comb begin
        wdata      = rd_a;
        carry_next = carry;
        case (op)
            OP_LOAD: wdata = bus_in;
            OP_INC: begin
                wdata      = inc_sum[WIDTH-1:0];
                carry_next = inc_sum[WIDTH];
`ifdef SWAP_REG_SAT_EN
                if (inc_sum[WIDTH]) wdata = rd_a;
`endif
            end
            OP_DEC: begin
                wdata      = dec_diff[WIDTH-1:0];
                carry_next = dec_diff[WIDTH];
`ifdef SWAP_REG_SAT_EN
                if (dec_diff[WIDTH]) wdata = rd_a;
`endif
            end
            OP_SWAP, OP_COPY: wdata = rd_b;
            OP_CLR:           wdata = '0;
            default:          wdata = rd_a;
        endcase
    end

    assign needs_b = (op == OP_SWAP) || (op == OP_COPY);
    assign accept  = en && (op != OP_NOP) && (op != OP_RSVD) && a_ok && (!needs_b || b_ok);
    assign reject  = en && (op != OP_NOP) && !accept;

    always_ff @(negedge clk) begin
        if (!rst) begin
            regs  <= {NREG{RST_W}};
            carry <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= accept;
            err <= reject;
            if (accept) begin
                carry <= carry_next;
                // sel_a wins on SWAP a==b, which writes back the same value.
                for (int i = 0; i < NREG; i++) begin
                    if (sel_a == AW'(i))
                        regs[i] <= wdata;
                    else if (op == OP_SWAP && sel_b == AW'(i))
                        regs[i] <= rd_a;
                end
            end
        end
    end

    assign regs_flat = regs;
    assign zero      = (rd_a == '0);

endmodule

// File: tb/tb_swap_reg_bank.sv
// tb/tb_swap_reg_bank.sv - table-driven check of swap_reg_bank (WIDTH=18, NREG=4, AW=3)
module tb_swap_reg_bank;

`ifdef SWAP_REG_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [2:0]  sel_a = 3'd0;
    logic [2:0]  sel_b = 3'd0;
    logic [17:0] bus_in = '0;
    logic [17:0] rd_a;
    logic [71:0] regs_flat;
    logic        zero, carry, ack, err;

    int tests = 0;
    int fails = 0;

    swap_reg_bank #(.WIDTH(18), .NREG(4), .AW(3), .RST_VAL(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .op(op), .sel_a(sel_a), .sel_b(sel_b),
        .bus_in(bus_in), .rd_a(rd_a), .regs_flat(regs_flat), .zero(zero),
        .carry(carry), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_v;
        logic        en_v;
        logic [2:0]  op_v;
        logic [2:0]  a_v;
        logic [2:0]  b_v;
        logic [17:0] bus_v;
        logic [71:0] exp_regs;
        logic        exp_carry;
        logic        exp_ack;
        logic        exp_err;
        logic [17:0] exp_rd;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [71:0] pk(input logic [17:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic add(input logic r, e, input logic [2:0] o, a, b, input logic [17:0] bus,
                       input logic [71:0] rg, input logic c, ak, er, input logic [17:0] rd);
        vec_t v;
        v.rst_v = r; v.en_v = e; v.op_v = o; v.a_v = a; v.b_v = b; v.bus_v = bus;
        v.exp_regs = rg; v.exp_carry = c; v.exp_ack = ak; v.exp_err = er;
        v.exp_rd = rd; v.exp_zero = (rd == 18'd0);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [71:0] act, exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Inputs change after the rising edge; outputs are sampled just after the falling edge.
    task automatic apply(input logic r, e, input logic [2:0] o, a, b, input logic [17:0] bus);
        @(posedge clk);
        rst = r; en = e; op = o; sel_a = a; sel_b = b; bus_in = bus;
        @(negedge clk);
        #1;
    endtask

    logic [17:0] r1_9, r1_10, r1_12;
    logic        c_10, c_11;

    initial begin
        r1_9  = SAT ? 18'h3FFFF : 18'h00000;
        r1_10 = SAT ? 18'h3FFFE : 18'h3FFFF;
        c_10  = SAT ? 1'b0 : 1'b1;
        c_11  = c_10;
        r1_12 = SAT ? 18'h00000 : 18'h3FFFF;

        //  rst en op    a     b     bus        regs after edge                          c     ack  err  rd_a
        add(0, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(4, 4, 4, 4),                           0,    0,   0,   18'd4);
        add(1, 1, 3'd1, 3'd2, 3'd0, 18'h2ABCD, pk(4, 4, 18'h2ABCD, 4),                   0,    1,   0,   18'h2ABCD);
        add(1, 0, 3'd1, 3'd2, 3'd0, 18'h0,     pk(4, 4, 18'h2ABCD, 4),                   0,    0,   0,   18'h2ABCD);
        add(1, 1, 3'd1, 3'd0, 3'd0, 18'd7,     pk(7, 4, 18'h2ABCD, 4),                   0,    1,   0,   18'd7);
        add(1, 1, 3'd1, 3'd3, 3'd0, 18'd9,     pk(7, 4, 18'h2ABCD, 9),                   0,    1,   0,   18'd9);
        add(1, 1, 3'd4, 3'd0, 3'd3, 18'h0,     pk(9, 4, 18'h2ABCD, 7),                   0,    1,   0,   18'd9);
        add(1, 1, 3'd6, 3'd1, 3'd0, 18'h0,     pk(9, 9, 18'h2ABCD, 7),                   0,    1,   0,   18'd9);
        add(1, 1, 3'd4, 3'd2, 3'd2, 18'h0,     pk(9, 9, 18'h2ABCD, 7),                   0,    1,   0,   18'h2ABCD);
        add(1, 1, 3'd1, 3'd1, 3'd0, 18'h3FFFF, pk(9, 18'h3FFFF, 18'h2ABCD, 7),           0,    1,   0,   18'h3FFFF);
        add(1, 1, 3'd2, 3'd1, 3'd0, 18'h0,     pk(9, r1_9, 18'h2ABCD, 7),                1,    1,   0,   r1_9);
        add(1, 1, 3'd3, 3'd1, 3'd0, 18'h0,     pk(9, r1_10, 18'h2ABCD, 7),               c_10, 1,   0,   r1_10);
        add(1, 1, 3'd5, 3'd1, 3'd0, 18'h0,     pk(9, 0, 18'h2ABCD, 7),                   c_11, 1,   0,   18'd0);
        add(1, 1, 3'd3, 3'd1, 3'd0, 18'h0,     pk(9, r1_12, 18'h2ABCD, 7),               1,    1,   0,   r1_12);
        add(1, 1, 3'd7, 3'd1, 3'd0, 18'h0,     pk(9, r1_12, 18'h2ABCD, 7),               1,    0,   1,   r1_12);
        add(1, 1, 3'd6, 3'd1, 3'd5, 18'h0,     pk(9, r1_12, 18'h2ABCD, 7),               1,    0,   1,   r1_12);
        add(1, 1, 3'd2, 3'd5, 3'd0, 18'h0,     pk(9, r1_12, 18'h2ABCD, 7),               1,    0,   1,   18'd0);
        add(1, 1, 3'd0, 3'd1, 3'd0, 18'h0,     pk(9, r1_12, 18'h2ABCD, 7),               1,    0,   0,   r1_12);
        add(1, 1, 3'd1, 3'd0, 3'd0, 18'd4,     pk(4, r1_12, 18'h2ABCD, 7),               1,    1,   0,   18'd4);
        add(1, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(5, r1_12, 18'h2ABCD, 7),               0,    1,   0,   18'd5);
        add(1, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(6, r1_12, 18'h2ABCD, 7),               0,    1,   0,   18'd6);
        add(1, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(7, r1_12, 18'h2ABCD, 7),               0,    1,   0,   18'd7);
        add(0, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(4, 4, 4, 4),                           0,    0,   0,   18'd4);
        add(1, 1, 3'd2, 3'd0, 3'd0, 18'h0,     pk(5, 4, 4, 4),                           0,    1,   0,   18'd5);

        foreach (vecs[i]) begin
            apply(vecs[i].rst_v, vecs[i].en_v, vecs[i].op_v, vecs[i].a_v, vecs[i].b_v, vecs[i].bus_v);
            chk("regs_flat", i, 72'(regs_flat), vecs[i].exp_regs);
            chk("carry",     i, 72'(carry),     72'(vecs[i].exp_carry));
            chk("ack",       i, 72'(ack),       72'(vecs[i].exp_ack));
            chk("err",       i, 72'(err),       72'(vecs[i].exp_err));
            chk("rd_a",      i, 72'(rd_a),      72'(vecs[i].exp_rd));
            chk("zero",      i, 72'(zero),      72'(vecs[i].exp_zero));
        end

        // Back-to-back INC on reg2 gives +2 with ack held high, then ack drops.
        apply(1, 1, 3'd1, 3'd2, 3'd0, 18'd10);
        apply(1, 1, 3'd2, 3'd2, 3'd0, 18'h0);
        chk("b2b_ack1", 100, 72'(ack), 72'(1));
        apply(1, 1, 3'd2, 3'd2, 3'd0, 18'h0);
        chk("b2b_ack2", 101, 72'(ack), 72'(1));
        chk("b2b_reg2", 102, 72'(regs_flat[36 +: 18]), 72'(12));
        apply(1, 0, 3'd2, 3'd2, 3'd0, 18'h0);
        chk("b2b_ack_drop", 103, 72'(ack), 72'(0));
        chk("b2b_hold", 104, 72'(regs_flat[36 +: 18]), 72'(12));

        // err is a single-cycle pulse.
        apply(1, 1, 3'd7, 3'd0, 3'd0, 18'h0);
        chk("err_pulse", 105, 72'(err), 72'(1));
        apply(1, 0, 3'd7, 3'd0, 3'd0, 18'h0);
        chk("err_drop", 106, 72'(err), 72'(0));
        chk("err_ack", 107, 72'(ack), 72'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
